keypad_scanner: RTL

Scans a 4×4 active-low matrix keypad, debounces it and reports each new key press as a 4-bit hex code. It sits directly upstream of the seven-segment decoder in the keypad-to-display path. Its `hex` output drives that decoder's 4-bit input. `key_valid` and `key_held` are available to game logic.

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_scanner_row_sync.sv | 24 ++
 rtl/keypad_scanner.sv | 138 +++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    // Key code per scan-image bit, indexed by row*NUM_COLS + col.
    // r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E(*) 0 F(#) D
    localparam logic [NUM_KEYS-1:0][3:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    // Result of classifying one complete scan image.
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } scan_class_t;

    // Press/release tracking state.
    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchroniser for the asynchronous, active-low keypad rows.
module row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Resets to all-ones so a reset never looks like a pressed key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, scan image, classifier, debounce, press FSM.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [3:0]          hex,
    output logic                key_valid,
    output logic                key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_FULL    = CW'(DEBOUNCE_SCANS);

    logic [NUM_ROWS-1:0] row_s;
    logic [DW-1:0]       dwell;
    logic [1:0]          col_idx;
    logic [NUM_KEYS-1:0] image;
    logic [NUM_KEYS-1:0] image_next;
    logic                sample;
    logic                scan_end;
    logic [4:0]          n_low;
    logic [3:0]          hit_code;
    scan_class_t         cls;
    scan_class_t         prev_cls;
    logic [3:0]          prev_code;
    logic [CW-1:0]       db_count;
    logic [CW-1:0]       db_next;
    state_t              state;

    row_sync #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row),
        .q   (row_s)
    );

    assign sample   = (dwell == DWELL_LAST);
    assign scan_end = sample && (col_idx == 2'd3);

    // Dwell counter and column rotation; col is registered alongside the index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell   <= '0;
            col_idx <= 2'd0;
            col     <= 4'b1110;
        end else if (sample) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            col     <= ~(4'b0001 << (col_idx + 2'd1));
        end else begin
            dwell   <= dwell + DW'(1);
        end
    end

    // Image with the current column's rows merged in; used on sample cycles.
    always_comb begin
        image_next = image;
        for (int r = 0; r < NUM_ROWS; r++)
            image_next[r*NUM_COLS + int'(col_idx)] = row_s[r];
    end

    // Scan image accumulates one column per dwell period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            image <= '1;
        else if (sample)
            image <= image_next;
    end

    // Classify the completed image: count low bits and look up the key code.
    always_comb begin
        n_low    = 5'd0;
        hit_code = 4'h0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!image_next[i]) begin
                n_low    = n_low + 5'd1;
                hit_code = KEY_MAP[i];
            end
        end
        if (n_low == 5'd0)
            cls = NONE;
        else if (n_low == 5'd1)
            cls = SINGLE;
        else
            cls = MULTI;
    end

    // Next debounce count: saturating increment on a repeat, else restart at 1.
    always_comb begin
        if (cls == prev_cls && (cls != SINGLE || hit_code == prev_code))
            db_next = (db_count == DB_FULL) ? db_count : db_count + CW'(1);
        else
            db_next = CW'(1);
    end

    // Debounce history and press FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prev_cls  <= NONE;
            prev_code <= 4'h0;
            db_count  <= '0;
            hex       <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_end) begin
                prev_cls  <= cls;
                prev_code <= hit_code;
                db_count  <= db_next;
                case (state)
                    IDLE: if (db_next == DB_FULL && cls == SINGLE) begin
                        hex       <= hit_code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        state     <= HELD;
                    end
                    // Only a debounced all-clear releases; other keys are ignored.
                    HELD: if (db_next == DB_FULL && cls == NONE) begin
                        key_held  <= 1'b0;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
